pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard controller for the 5-stage core. It replaces the separate

---
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use stall and jump/branch flush.
// Optional build macro R0_ZERO_EN treats register 0 as hard-wired zero (no forwarding, no stalls on it).
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 3,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_use,
  input  logic              id_rs2_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wb,
  input  logic              id_load,
  input  logic              ex_jump,
  input  logic              mem_branch,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

`ifdef R0_ZERO_EN
  localparam bit R0_HARD = 1'b1;
`else
  localparam bit R0_HARD = 1'b0;
`endif

  function automatic logic is_r0(input logic [REG_AW-1:0] r);
    return R0_HARD && (r == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ID/EX tag (p0)
  logic              vld_p0;
  logic [REG_AW-1:0] rs1_p0, rs2_p0, rd_p0;
  logic              u1_p0, u2_p0, wb_p0, ld_p0;

  // Post-EX tags, index k = stage k after EX
  logic              vld_px [1:FWD_DEPTH];
  logic [REG_AW-1:0] rd_px  [1:FWD_DEPTH];
  logic              wb_px  [1:FWD_DEPTH];
  logic              ld_px  [1:FWD_DEPTH];

  logic hz, any_flush, stall_eff;

  // Scan oldest to youngest so the youngest matching producer is the last write.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (vld_px[k] && wb_px[k] && !is_r0(rd_px[k]) && !(k == 1 && ld_px[k])) begin
        if (vld_p0 && u1_p0 && !is_r0(rs1_p0) && rd_px[k] == rs1_p0) fwd_sel_a = SEL_W'(k);
        if (vld_p0 && u2_p0 && !is_r0(rs2_p0) && rd_px[k] == rs2_p0) fwd_sel_b = SEL_W'(k);
      end
    end
  end

  always_comb begin
    hz = id_valid && vld_p0 && ld_p0 && wb_p0 && !is_r0(rd_p0) &&
         ((id_rs1_use && id_rs1 == rd_p0) || (id_rs2_use && id_rs2 == rd_p0));
    flush_exmem = mem_branch;
    flush_idex  = mem_branch || ex_jump;
    flush_ifid  = mem_branch || ex_jump;
    any_flush   = flush_idex;
    stall_eff   = hz && !any_flush;
    stall_pc    = stall_eff;
    stall_ifid  = stall_eff;
    bubble_idex = stall_eff;
  end

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= (flush_idex || bubble_idex) ? 1'b0 : id_valid;
    rs1_p0 <= id_rs1;
    rs2_p0 <= id_rs2;
    u1_p0  <= id_rs1_use;
    u2_p0  <= id_rs2_use;
    rd_p0  <= id_rd;
    wb_p0  <= id_wb;
    ld_p0  <= id_load;
  end

  // EX -> post-EX stage boundaries
  always_ff @(posedge clk) begin
    if (reset) vld_px[1] <= 1'b0;
    else       vld_px[1] <= flush_exmem ? 1'b0 : vld_p0;
    rd_px[1] <= rd_p0;
    wb_px[1] <= wb_p0;
    ld_px[1] <= ld_p0;
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      if (reset) vld_px[k] <= 1'b0;
      else       vld_px[k] <= vld_px[k-1];
      rd_px[k] <= rd_px[k-1];
      wb_px[k] <= wb_px[k-1];
      ld_px[k] <= ld_px[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_eff) stall_cnt <= sat_inc(stall_cnt);
      if (any_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic
// compared against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;
  localparam int RA = 3;
  localparam int D  = 2;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  typedef struct packed {
    logic v; logic [RA-1:0] rs1; logic [RA-1:0] rs2; logic u1; logic u2;
    logic [RA-1:0] rd; logic wb; logic ld;
  } ins_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 0, id_rs1_use = 0, id_rs2_use = 0, id_wb = 0, id_load = 0;
  logic [RA-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic ex_jump = 0, mem_branch = 0;
  logic [SW-1:0] fwd_sel_a, fwd_sel_b;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, flush_exmem;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(RA), .FWD_DEPTH(D), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_rd(id_rd), .id_wb(id_wb),
    .id_load(id_load), .ex_jump(ex_jump), .mem_branch(mem_branch),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction-level model: the instruction in EX and the ones that left it.
  ins_t m_ex = '0;
  ins_t m_post [1:D];
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic bit zreg(input logic [RA-1:0] r);
    return R0 && r == '0;
  endfunction

  function automatic ins_t cur_ins();
    ins_t i;
    i.v = id_valid; i.rs1 = id_rs1; i.rs2 = id_rs2; i.u1 = id_rs1_use; i.u2 = id_rs2_use;
    i.rd = id_rd; i.wb = id_wb; i.ld = id_load;
    return i;
  endfunction

  // Distance to the youngest in-flight writer of rs whose result is available.
  function automatic int exp_sel(input logic [RA-1:0] rs, input logic u);
    if (!m_ex.v || !u || zreg(rs)) return 0;
    for (int k = 1; k <= D; k++) begin
      if (m_post[k].v && m_post[k].wb && m_post[k].rd == rs && !zreg(rs)) begin
        if (!(k == 1 && m_post[k].ld)) return k;
      end
    end
    return 0;
  endfunction

  function automatic bit exp_hz();
    ins_t i = cur_ins();
    if (!(i.v && m_ex.v && m_ex.ld && m_ex.wb) || zreg(m_ex.rd)) return 0;
    return (i.u1 && i.rs1 == m_ex.rd) || (i.u2 && i.rs2 == m_ex.rd);
  endfunction

  always @(posedge clk) begin
    bit fl, st;
    fl = ex_jump || mem_branch;
    st = exp_hz() && !fl;
    if (reset) begin
      m_ex = '0;
      for (int k = 1; k <= D; k++) m_post[k] = '0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      for (int k = D; k >= 2; k--) m_post[k] = m_post[k-1];
      m_post[1] = mem_branch ? '0 : m_ex;
      m_ex = (fl || st) ? '0 : cur_ins();
      if (st && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
    end
  end

  task automatic check_all();
    bit fl3, fl2, st;
    fl3 = mem_branch;
    fl2 = mem_branch || ex_jump;
    st  = exp_hz() && !fl2;
    chk("fwd_sel_a", fwd_sel_a, exp_sel(m_ex.rs1, m_ex.u1));
    chk("fwd_sel_b", fwd_sel_b, exp_sel(m_ex.rs2, m_ex.u2));
    chk("stall_pc", stall_pc, st);
    chk("stall_ifid", stall_ifid, st);
    chk("bubble_idex", bubble_idex, st);
    chk("flush_ifid", flush_ifid, fl2);
    chk("flush_idex", flush_idex, fl2);
    chk("flush_exmem", flush_exmem, fl3);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic cyc(input ins_t i, input bit jmp, input bit br, input bit rst, input bit do_chk);
    @(negedge clk);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_use = i.u1; id_rs2_use = i.u2;
    id_rd = i.rd; id_wb = i.wb; id_load = i.ld;
    ex_jump = jmp; mem_branch = br; reset = rst;
    #1;
    if (do_chk) check_all();
  endtask

  function automatic ins_t mk(input int rd, input bit wb, input bit ld,
                              input int rs1, input bit u1, input int rs2, input bit u2);
    ins_t i;
    i.v = 1'b1; i.rd = RA'(rd); i.wb = wb; i.ld = ld;
    i.rs1 = RA'(rs1); i.u1 = u1; i.rs2 = RA'(rs2); i.u2 = u2;
    return i;
  endfunction

  task automatic do_reset();
    cyc('0, 0, 0, 1, 0);
    cyc('0, 0, 0, 1, 0);
  endtask

  initial begin
    ins_t nop, add_r1, ld_r3, use_r3, ri;
    nop = '0;
    for (int k = 1; k <= D; k++) m_post[k] = '0;

    do_reset();
    cyc(nop, 0, 0, 0, 1);
    chk("rst_sel_a", fwd_sel_a, 0);
    chk("rst_stall", {stall_pc, stall_ifid, bubble_idex}, 0);
    chk("rst_flush", {flush_ifid, flush_idex, flush_exmem}, 0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 0);

    add_r1 = mk(1, 1, 0, 6, 0, 7, 0);
    do_reset();
    cyc(add_r1, 0, 0, 0, 1);
    cyc(mk(2, 1, 0, 5, 1, 1, 1), 0, 0, 0, 1);
    cyc(nop, 0, 0, 0, 1);
    chk("fwd_b_adjacent", fwd_sel_b, 1);

    do_reset();
    cyc(add_r1, 0, 0, 0, 1);
    cyc(nop, 0, 0, 0, 1);
    cyc(mk(2, 1, 0, 5, 1, 1, 1), 0, 0, 0, 1);
    cyc(nop, 0, 0, 0, 1);
    chk("fwd_b_gap", fwd_sel_b, 2);

    ld_r3 = mk(3, 1, 1, 6, 0, 7, 0);
    use_r3 = mk(4, 1, 0, 3, 1, 6, 1);
    do_reset();
    cyc(ld_r3, 0, 0, 0, 1);
    cyc(use_r3, 0, 0, 0, 1);
    chk("lu_stall", {stall_pc, stall_ifid, bubble_idex}, 3'b111);
    cyc(use_r3, 0, 0, 0, 1);
    chk("lu_stall_once", {stall_pc, stall_ifid, bubble_idex}, 0);
    cyc(nop, 0, 0, 0, 1);
    chk("lu_fwd_a", fwd_sel_a, 2);
    chk("lu_stall_cnt", stall_cnt, 1);

    do_reset();
    cyc(add_r1, 0, 0, 0, 1);
    cyc(add_r1, 0, 0, 0, 1);
    cyc(mk(5, 1, 0, 1, 1, 6, 0), 0, 0, 0, 1);
    cyc(nop, 0, 0, 0, 1);
    chk("youngest_a", fwd_sel_a, 1);

    do_reset();
    cyc(ld_r3, 0, 0, 0, 1);
    cyc(use_r3, 1, 1, 0, 1);
    chk("jb_flush", {flush_ifid, flush_idex, flush_exmem}, 3'b111);
    chk("jb_nostall", {stall_pc, stall_ifid, bubble_idex}, 0);
    cyc(nop, 0, 0, 0, 1);
    chk("jb_flush_cnt", flush_cnt, 1);

    do_reset();
    cyc(mk(0, 1, 1, 6, 0, 7, 0), 0, 0, 0, 1);
    cyc(mk(1, 1, 0, 0, 1, 6, 0), 0, 0, 0, 1);
    chk("r0_load_stall", stall_pc, R0 ? 0 : 1);
    do_reset();
    cyc(mk(0, 1, 0, 6, 0, 7, 0), 0, 0, 0, 1);
    cyc(mk(1, 1, 0, 0, 1, 6, 0), 0, 0, 0, 1);
    cyc(nop, 0, 0, 0, 1);
    chk("r0_fwd_a", fwd_sel_a, R0 ? 0 : 1);

    do_reset();
    for (int n = 0; n < 20; n++) cyc(nop, 1, 0, 0, 1);
    cyc(nop, 0, 0, 0, 1);
    chk("flush_sat", flush_cnt, CMAX);
    do_reset();
    for (int n = 0; n < 20; n++) begin
      cyc(ld_r3, 0, 0, 0, 1);
      cyc(use_r3, 0, 0, 0, 1);
    end
    cyc(nop, 0, 0, 0, 1);
    chk("stall_sat", stall_cnt, CMAX);

    do_reset();
    for (int n = 0; n < 600; n++) begin
      ri.v = ($urandom_range(0, 9) != 0);
      ri.rs1 = RA'($urandom_range(0, 3)); ri.rs2 = RA'($urandom_range(0, 3));
      ri.u1 = 1'($urandom); ri.u2 = 1'($urandom);
      ri.rd = RA'($urandom_range(0, 3)); ri.wb = ($urandom_range(0, 3) != 0);
      ri.ld = ($urandom_range(0, 2) == 0);
      cyc(ri, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 49) == 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
